// File: rtl/parity_pkg.sv
// Shared definitions for the even-parity generator and the parity frame
// transmitter: frame geometry, FSM state encoding and the parity reduction.
package parity_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int FRAME_BITS = 7;  // start + 4 data + parity + stop

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Even parity of a nibble: 1 when the nibble holds an odd number of ones,
    // so that nibble plus parity bit always carries an even count.
    function automatic logic even_parity(input logic [NIBBLE_W-1:0] nibble);
        return ^nibble;
    endfunction

endpackage

// File: rtl/parity_frame_tx_if.sv
// Handshake and serial-line bundle of the parity frame transmitter.
// master = upstream producer / line observer, slave = the transmitter.
interface parity_frame_tx_if;

    logic                              in_valid;
    logic                              in_ready;
    logic [parity_pkg::NIBBLE_W-1:0]   data_in;
    logic                              parity_in;
    logic                              tx_out;
    logic                              busy;
    logic                              done;
    logic                              parity_err;

    modport master (
        output in_valid, data_in, parity_in,
        input  in_ready, tx_out, busy, done, parity_err
    );

    modport slave (
        input  in_valid, data_in, parity_in,
        output in_ready, tx_out, busy, done, parity_err
    );

endinterface

// File: rtl/parity_frame_tx_bit_timer.sv
// Per-bit cycle counter. Counts 0..CLKS_PER_BIT-1, wraps on tick, and is held
// at 0 while clear is high. tick_next announces that the following cycle is
// the last one of a bit, which lets registered outputs line up with tick.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic tick_next
);

    localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    assign tick      = (r_cnt == LAST);
    assign tick_next = (w_cnt_next == LAST);

    // Next count: restart on clear or at the end of a bit, else increment.
    always_comb begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (clear || tick) begin
            w_cnt_next = '0;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/parity_frame_tx.sv
// Serializes a nibble and its even-parity bit as start, d0..d3, parity, stop.
// All line-side outputs are registered; they are computed from the next
// state so that accepting on edge N drives the start bit from edge N.
module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    parity_frame_tx_if.slave   bus
);

    localparam int SHIFT_W = NIBBLE_W + 1;

    state_t               r_state;
    logic [SHIFT_W-1:0]   r_shift;
    logic [1:0]           r_idx;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_perr;

    state_t               w_state_next;
    logic [SHIFT_W-1:0]   w_shift_next;
    logic [1:0]           w_idx_next;
    logic                 w_tx_next;
    logic                 w_busy_next;
    logic                 w_done_next;
    logic                 w_perr_next;
    logic                 w_accept;
    logic                 w_clear;
    logic                 w_tick;
    logic                 w_tick_next;

    // The timer idles at zero so the first START cycle is count 0.
    assign w_clear  = (r_state == IDLE);
    assign w_accept = bus.in_valid && (r_state == IDLE);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .tick      (w_tick),
        .tick_next (w_tick_next)
    );

    // Next-state logic plus the registered outputs derived from that next state.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_idx_next   = r_idx;
        w_perr_next  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = START;
                    w_shift_next = {bus.parity_in, bus.data_in};
                    w_idx_next   = 2'd0;
                    w_perr_next  = (bus.parity_in != even_parity(bus.data_in));
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    // The fourth shift leaves the parity bit in shift[0].
                    w_shift_next = {1'b0, r_shift[SHIFT_W-1:1]};
                    w_idx_next   = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        w_tx_next = 1'b1;
        unique case (w_state_next)
            START:       w_tx_next = 1'b0;
            DATA,
            PARITY:      w_tx_next = w_shift_next[0];
            default:     w_tx_next = 1'b1;
        endcase

        w_busy_next = (w_state_next != IDLE);
        // High during the final STOP cycle, i.e. the cycle in which tick fires.
        w_done_next = (w_state_next == STOP) && w_tick_next;
    end

    // State and output registers; reset wins over any acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= 2'd0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_idx   <= w_idx_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_perr  <= w_perr_next;
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.tx_out     = r_tx;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.parity_err = r_perr;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx. Two instances (CLKS_PER_BIT 4 and 1)
// share the stimulus; sel picks which one receives in_valid and is observed.
// Expected per-cycle line values are queued on each send and popped per cycle.
module tb_parity_frame_tx;
    import parity_pkg::*;

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
        logic perr;
        logic ready;
    } obs_t;

    localparam obs_t IDLE_OBS = '{tx: 1'b1, busy: 1'b0, done: 1'b0, perr: 1'b0, ready: 1'b1};

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       par;
    logic [3:0] data;
    logic       sel;
    int         n_tests = 0;
    int         n_fail  = 0;
    obs_t       exp_q[$];
    obs_t       w_obs;

    always #5 clk = ~clk;

    parity_frame_tx_if if4 ();
    parity_frame_tx_if if1 ();

    assign if4.in_valid  = valid & ~sel;
    assign if4.data_in   = data;
    assign if4.parity_in = par;
    assign if1.in_valid  = valid & sel;
    assign if1.data_in   = data;
    assign if1.parity_in = par;

    parity_frame_tx #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    assign w_obs = sel ? {if1.tx_out, if1.busy, if1.done, if1.parity_err, if1.in_ready}
                       : {if4.tx_out, if4.busy, if4.done, if4.parity_err, if4.in_ready};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (tx,busy,done,perr,ready)",
                   tag, observed[4:0], expected[4:0]);
        end
    endtask

    // Queue the expected line state for every cycle of one frame.
    function automatic void push_frame(input logic [3:0] d, input logic p, input int c);
        logic [FRAME_BITS-1:0] bits;
        logic                  mismatch;
        obs_t                  e;
        bits     = {1'b1, p, d, 1'b0};
        mismatch = (p != even_parity(d));
        for (int k = 0; k < FRAME_BITS * c; k++) begin
            e.tx    = bits[k / c];
            e.busy  = 1'b1;
            e.done  = (k == FRAME_BITS * c - 1);
            e.perr  = mismatch && (k == 0);
            e.ready = 1'b0;
            exp_q.push_back(e);
        end
    endfunction

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s idle%0d", tag, i), 32'(w_obs), 32'(IDLE_OBS));
        end
    endtask

    // Present a nibble, wait (bounded) for acceptance, then compare each frame
    // cycle. stop_after > 0 ends the comparison early and drops the rest.
    task automatic send(input string tag, input logic [3:0] d, input logic p,
                        input int c, input bit keep_valid, input int stop_after);
        int   waited;
        int   cyc;
        obs_t e;
        waited = 0;
        cyc    = 0;
        data   = d;
        par    = p;
        valid  = 1'b1;
        while (w_obs.ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " accept_wait"}, 32'(waited < 50), 32'd1);
        push_frame(d, p, c);
        @(negedge clk);
        if (!keep_valid) valid = 1'b0;
        data = ~d;
        par  = ~p;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s cyc%0d", tag, cyc), 32'(w_obs), 32'(e));
            cyc++;
            if (stop_after > 0 && cyc >= stop_after) exp_q.delete();
            if (exp_q.size() > 0) @(negedge clk);
        end
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        data  = 4'h0;
        par   = 1'b0;
        sel   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and quiet idle line.
        idle_check("reset4", 10);

        // Nominal frame, correct parity.
        send("f1011", 4'b1011, 1'b1, 4, 1'b0, 0);
        idle_check("gap1", 2);

        // Wrong parity: flagged once, transmitted unchanged.
        send("perr0110", 4'b0110, 1'b1, 4, 1'b0, 0);
        idle_check("gap2", 1);

        // Back-to-back with in_valid held: exactly one ready cycle between.
        send("b2b_3", 4'h3, 1'b0, 4, 1'b1, 0);
        data = 4'hC;
        par  = 1'b0;
        @(negedge clk);
        check("b2b_gap", 32'(w_obs), 32'(IDLE_OBS));
        send("b2b_C", 4'hC, 1'b0, 4, 1'b0, 0);
        idle_check("gap3", 1);

        // Reset in the middle of a frame, with a new request already pending.
        send("rst_frame", 4'h5, 1'b0, 4, 1'b0, 10);
        rst   = 1'b1;
        valid = 1'b1;
        data  = 4'h9;
        par   = 1'b0;
        @(negedge clk);
        check("rst_midframe", 32'(w_obs), 32'(IDLE_OBS));
        rst = 1'b0;
        send("post_rst", 4'h9, 1'b0, 4, 1'b0, 0);
        idle_check("gap4", 1);

        // Reset and a request in the same idle cycle: reset wins.
        rst   = 1'b1;
        valid = 1'b1;
        data  = 4'h2;
        par   = 1'b1;
        @(negedge clk);
        check("rst_priority", 32'(w_obs), 32'(IDLE_OBS));
        rst   = 1'b0;
        valid = 1'b0;
        idle_check("after_prio", 2);

        // One clock per bit.
        sel = 1'b1;
        idle_check("idle1", 2);
        send("c1_F", 4'hF, 1'b0, 1, 1'b0, 0);
        idle_check("c1_gap", 2);
        send("c1_perrA", 4'hA, 1'b1, 1, 1'b0, 0);
        idle_check("c1_end", 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
